// File: rtl/lift_pkg.sv
// Shared widths, FSM state encoding and state helpers for the lift-port master.
package lift_pkg;

  localparam int LIFT_ADDR_W = 9;
  localparam int LIFT_DATA_W = 240;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_RD_DRAIN = 3'd2,
    ST_WR       = 3'd3,
    ST_DONE     = 3'd4
  } lift_state_e;

  // The lift port is owned (interrupt raised) only while lines are moving.
  function automatic logic lift_owned(input lift_state_e st);
    return (st == ST_RD) || (st == ST_RD_DRAIN) || (st == ST_WR);
  endfunction

endpackage

// File: rtl/lift_skid_fifo.sv
// Two-entry line buffer between the lift read port and the outgoing stream.
module lift_skid_fifo
  import lift_pkg::*;
#(
  parameter int WIDTH = LIFT_DATA_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  // Storage, pointers and occupancy; the master never pushes into a full buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/lift_port_master.sv
// Moves runs of lines between the lift memory port and a read/write stream pair.
module lift_port_master
  import lift_pkg::*;
#(
  parameter int ADDR_W = LIFT_ADDR_W,
  parameter int DATA_W = LIFT_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              busy,
  output logic              done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              lift_interrupt,
  output logic [ADDR_W-1:0] lift_address,
  output logic              lift_we,
  output logic [DATA_W-1:0] lift_wr_data,
  input  logic [DATA_W-1:0] lift_rd_data
);

  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  lift_state_e       r_state;
  lift_state_e       w_next;
  logic              r_busy;
  logic              r_irq;
  logic              r_done;
  logic              r_cmd_ready;
  logic              r_s_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_issue_left;
  logic [ADDR_W:0]   r_pop_left;
  logic              r_inflight;
  logic [1:0]        w_count;
  logic [2:0]        w_occ;
  logic              w_accept;
  logic              w_issue;
  logic              w_pop;
  logic              w_we;
  logic              w_m_valid;

  assign w_accept  = cmd_valid && r_cmd_ready;
  assign w_m_valid = (w_count != 2'd0);
  assign w_pop     = w_m_valid && m_ready;
  assign w_we      = r_s_ready && s_valid;
  // A line popped this cycle frees its slot in time for a read issued now.
  assign w_occ     = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = (r_state == ST_RD) && (r_issue_left != '0) && (w_occ < 3'd2);

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cmd_len == '0) begin
            w_next = ST_DONE;
          end else if (cmd_write) begin
            w_next = ST_WR;
          end else begin
            w_next = ST_RD;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RD: begin
        if (w_issue && (r_issue_left == LEN_ONE)) begin
          w_next = ST_RD_DRAIN;
        end else begin
          w_next = ST_RD;
        end
      end
      ST_RD_DRAIN: begin
        if (w_pop && (r_pop_left == LEN_ONE)) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_RD_DRAIN;
        end
      end
      ST_WR: begin
        if (w_we && (r_issue_left == LEN_ONE)) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_WR;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register with status flags registered from the upcoming state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_irq       <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_s_ready   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != ST_IDLE);
      r_irq       <= lift_owned(w_next);
      r_done      <= (w_next == ST_DONE);
      r_cmd_ready <= (w_next == ST_IDLE);
      r_s_ready   <= (w_next == ST_WR);
    end
  end

  // Address and line counters; issue and pop sides are counted separately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr       <= '0;
      r_issue_left <= '0;
      r_pop_left   <= '0;
      r_inflight   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_addr       <= cmd_base;
        r_issue_left <= cmd_len;
        r_pop_left   <= cmd_len;
      end else begin
        if (w_issue || w_we) begin
          r_addr       <= r_addr + ADDR_ONE;
          r_issue_left <= r_issue_left - LEN_ONE;
        end
        if (w_pop) begin
          r_pop_left <= r_pop_left - LEN_ONE;
        end
      end
    end
  end

  lift_skid_fifo #(
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (r_inflight),
    .i_data  (lift_rd_data),
    .i_pop   (w_pop),
    .o_data  (m_data),
    .o_count (w_count)
  );

  assign cmd_ready      = r_cmd_ready;
  assign busy           = r_busy;
  assign done           = r_done;
  assign m_valid        = w_m_valid;
  assign m_last         = w_m_valid && (r_pop_left == LEN_ONE);
  assign s_ready        = r_s_ready;
  assign lift_interrupt = r_irq;
  assign lift_address   = r_irq ? r_addr : '0;
  assign lift_we        = w_we;
  assign lift_wr_data   = w_we ? s_data : '0;

endmodule

// File: tb/tb_lift_port_master.sv
// Scoreboard bench for lift_port_master with a one-cycle-latency memory model.
module tb_lift_port_master;

  logic         clk;
  logic         rstn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [8:0]   cmd_base;
  logic [9:0]   cmd_len;
  logic         busy;
  logic         done;
  logic         m_valid;
  logic         m_ready;
  logic [239:0] m_data;
  logic         m_last;
  logic         s_valid;
  logic         s_ready;
  logic [239:0] s_data;
  logic         lift_interrupt;
  logic [8:0]   lift_address;
  logic         lift_we;
  logic [239:0] lift_wr_data;
  logic [239:0] rd_q;

  logic [239:0] mem     [512];
  logic [239:0] ref_mem [512];
  logic [240:0] exp_rd [$];
  logic [248:0] exp_wr [$];

  int n_vec, n_err;
  int cyc, done_cnt, done_cyc, pop_cnt, wr_cnt, irq_cnt;
  int first_pop_cyc, last_pop_cyc;
  bit first_pending;

  lift_port_master dut (
    .clk            (clk),
    .rstn           (rstn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_base       (cmd_base),
    .cmd_len        (cmd_len),
    .busy           (busy),
    .done           (done),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .lift_interrupt (lift_interrupt),
    .lift_address   (lift_address),
    .lift_we        (lift_we),
    .lift_wr_data   (lift_wr_data),
    .lift_rd_data   (rd_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory behind the lift port: synchronous write, read data one cycle after the address.
  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 240'(k);
    forever begin
      @(posedge clk);
      if (lift_we) mem[lift_address] <= lift_wr_data;
      rd_q <= mem[lift_address];
    end
  end

  // Cycle counter and output monitor (sampled on the falling edge).
  initial begin
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        logic [240:0] e;
        logic [248:0] w;
        @(negedge clk);
        if (rstn) begin
          if (!lift_interrupt) chk("addr_idle", 256'(lift_address), 256'(0));
          if (lift_interrupt) irq_cnt++;
          if (done) begin
            done_cnt++;
            done_cyc = cyc;
          end
          if (m_valid && m_ready) begin
            chk("rd_expected", 256'(exp_rd.size() != 0), 256'(1));
            if (exp_rd.size() != 0) begin
              e = exp_rd.pop_front();
              chk("rd_data", 256'(m_data), 256'(e[239:0]));
              chk("rd_last", 256'(m_last), 256'(e[240]));
            end
            pop_cnt++;
            last_pop_cyc = cyc;
            if (first_pending) begin
              first_pop_cyc = cyc;
              first_pending = 1'b0;
            end
          end
          if (lift_we) begin
            chk("wr_irq", 256'(lift_interrupt), 256'(1));
            chk("wr_expected", 256'(exp_wr.size() != 0), 256'(1));
            if (exp_wr.size() != 0) begin
              w = exp_wr.pop_front();
              chk("wr_addr", 256'(lift_address), 256'(w[248:240]));
              chk("wr_data", 256'(lift_wr_data), 256'(w[239:0]));
            end
            wr_cnt++;
          end
        end
      end
    join_none
  end

  task automatic do_read(input int base, input int len, input bit toggle);
    int d0, p0, cycles, a;
    for (int k = 0; k < len; k++) begin
      a = (base + k) % 512;
      exp_rd.push_back({(k == len - 1), ref_mem[a]});
    end
    d0 = done_cnt;
    p0 = pop_cnt;
    first_pending = 1'b1;
    cmd_base  = 9'(base);
    cmd_len   = 10'(len);
    cmd_write = 1'b0;
    cmd_valid = 1'b1;
    m_ready   = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rd_busy", 256'(busy), 256'(1));
    chk("rd_irq", 256'(lift_interrupt), 256'(1));
    chk("rd_cmd_ready_low", 256'(cmd_ready), 256'(0));
    @(posedge clk); #1;
    chk("rd_lat1", 256'(m_valid), 256'(0));
    @(posedge clk); #1;
    chk("rd_lat2", 256'(m_valid), 256'(1));
    cycles = 0;
    while (done_cnt == d0 && cycles < 300) begin
      if (toggle) m_ready = ~m_ready;
      @(posedge clk); #1;
      cycles++;
    end
    m_ready = 1'b1;
    chk("rd_done", 256'(done_cnt - d0), 256'(1));
    chk("rd_lines", 256'(pop_cnt - p0), 256'(len));
    chk("rd_q_empty", 256'(exp_rd.size()), 256'(0));
    chk("rd_done_cyc", 256'(done_cyc), 256'(last_pop_cyc + 1));
    if (!toggle) chk("rd_streak", 256'(last_pop_cyc - first_pop_cyc), 256'(len - 1));
    chk("rd_cmd_ready_back", 256'(cmd_ready), 256'(1));
    chk("rd_irq_off", 256'(lift_interrupt), 256'(0));
  endtask

  task automatic do_write(input int base, input int len);
    logic [239:0] vals [$];
    logic [255:0] tmp;
    int d0, w0, cycles, a;
    bit acc;
    for (int k = 0; k < len; k++) begin
      tmp = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      a = (base + k) % 512;
      vals.push_back(tmp[239:0]);
      ref_mem[a] = tmp[239:0];
      exp_wr.push_back({9'(a), tmp[239:0]});
    end
    d0 = done_cnt;
    w0 = wr_cnt;
    cmd_base  = 9'(base);
    cmd_len   = 10'(len);
    cmd_write = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("wr_s_ready", 256'(s_ready), 256'(1));
    for (int k = 0; k < len; k++) begin
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = vals[k];
      cycles  = 0;
      do begin
        acc = s_ready;
        @(posedge clk); #1;
        cycles++;
      end while (!acc && cycles < 20);
      s_valid = 1'b0;
      s_data  = '0;
    end
    cycles = 0;
    while (done_cnt == d0 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("wr_done", 256'(done_cnt - d0), 256'(1));
    chk("wr_we_cycles", 256'(wr_cnt - w0), 256'(len));
    chk("wr_q_empty", 256'(exp_wr.size()), 256'(0));
    chk("wr_s_ready_off", 256'(s_ready), 256'(0));
  endtask

  initial begin
    int d0, i0, p0, cycles;
    n_vec = 0; n_err = 0; cyc = 0;
    done_cnt = 0; done_cyc = 0; pop_cnt = 0; wr_cnt = 0; irq_cnt = 0;
    first_pop_cyc = 0; last_pop_cyc = 0; first_pending = 1'b0;
    for (int k = 0; k < 512; k++) ref_mem[k] = 240'(k);
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
    m_ready = 1'b1; s_valid = 1'b0; s_data = '0;
    #12;
    chk("rst_cmd_ready", 256'(cmd_ready), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_m_valid", 256'(m_valid), 256'(0));
    chk("rst_irq", 256'(lift_interrupt), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    #10 rstn = 1'b1;
    @(posedge clk); #1;
    chk("rel_cmd_ready", 256'(cmd_ready), 256'(1));

    do_read(0, 4, 1'b0);
    do_read(510, 4, 1'b0);
    do_read(40, 8, 1'b1);
    do_write(5, 3);
    do_read(5, 3, 1'b0);

    // Zero-length command: straight to the done pulse.
    i0 = irq_cnt; d0 = done_cnt;
    cmd_base = 9'd77; cmd_len = 10'd0; cmd_write = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("len0_busy", 256'(busy), 256'(1));
    chk("len0_done", 256'(done), 256'(1));
    chk("len0_cmd_ready", 256'(cmd_ready), 256'(0));
    @(posedge clk); #1;
    chk("len0_done_off", 256'(done), 256'(0));
    chk("len0_cmd_ready_back", 256'(cmd_ready), 256'(1));
    chk("len0_one_done", 256'(done_cnt - d0), 256'(1));
    chk("len0_no_irq", 256'(irq_cnt - i0), 256'(0));

    // Reset in the middle of a read after three lines.
    for (int k = 0; k < 8; k++) exp_rd.push_back({(k == 7), ref_mem[20 + k]});
    p0 = pop_cnt;
    cmd_base = 9'd20; cmd_len = 10'd8; cmd_write = 1'b0; cmd_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cycles = 0;
    while (pop_cnt - p0 < 3 && cycles < 50) begin
      @(posedge clk);
      cycles++;
    end
    chk("mid_pops", 256'(pop_cnt - p0), 256'(3));
    #2 rstn = 1'b0;
    #1;
    chk("mid_irq", 256'(lift_interrupt), 256'(0));
    chk("mid_m_valid", 256'(m_valid), 256'(0));
    chk("mid_we", 256'(lift_we), 256'(0));
    chk("mid_busy", 256'(busy), 256'(0));
    chk("mid_addr", 256'(lift_address), 256'(0));
    d0 = done_cnt;
    exp_rd.delete();
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    chk("mid_no_done", 256'(done_cnt - d0), 256'(0));
    chk("mid_cmd_ready", 256'(cmd_ready), 256'(1));
    do_read(100, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
